// File: rtl/ixc_readback_pkg.sv
// ixc_readback_pkg
//   Shared definitions for the ixc_readback_21 probe readback block:
//   FSM state enum, beat-count helper and the beat-index width.
package ixc_readback_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_e;

    // Width of rd_idx; covers up to four beats.
    localparam int IDX_W = 2;

    // Number of BEAT-wide slices needed to cover a WIDTH-bit word.
    function automatic int num_beats(input int width, input int beat);
        return (width + beat - 1) / beat;
    endfunction

endpackage

// File: rtl/ixc_readback_shreg.sv
// ixc_readback_shreg
//   Shadow register for a captured probe word, zero-padded to a whole
//   number of beats. The current beat is always the low BEAT bits; each
//   advance shifts the next slice down, so the top beat reads 0 above WIDTH.
// Ports:
//   clk, rst   clock, synchronous active-high reset (clears shadow)
//   load_i     capture word_i into the shadow register
//   adv_i      shift to the next beat
//   word_i     word to capture
//   beat_o     current beat slice
module ixc_readback_shreg
    import ixc_readback_pkg::*;
#(
    parameter int WIDTH = 21,
    parameter int BEAT  = 7
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_i,
    input  logic             adv_i,
    input  logic [WIDTH-1:0] word_i,
    output logic [BEAT-1:0]  beat_o
);

    localparam int NB = num_beats(WIDTH, BEAT);
    localparam int SW = NB * BEAT;

    logic [SW-1:0] shadow_q, shadow_d;

    always_comb begin
        shadow_d = shadow_q;
        if (load_i)
            shadow_d = SW'(word_i);
        else if (adv_i)
            shadow_d = shadow_q >> BEAT;
    end

    always_ff @(posedge clk) begin
        if (rst)
            shadow_q <= '0;
        else
            shadow_q <= shadow_d;
    end

    assign beat_o = shadow_q[BEAT-1:0];

endmodule

// File: rtl/ixc_readback_21.sv
// ixc_readback_21
//   Captures a probe word on snap_req and streams it to a host as
//   NUM_BEATS LSB-first beats over a valid/ready handshake.
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   probe               word to capture
//   snap_req            single-cycle capture request
//   snap_busy           high while beats remain to be transferred
//   snap_ovf            sticky: snap_req seen while busy
//   rd_valid/rd_ready   beat handshake
//   rd_data/rd_idx      current beat and its index
//   rd_last             current beat is the final one
//   rd_par              even parity over rd_data (only with
//                       IXC_READBACK_PARITY_EN defined)
module ixc_readback_21
    import ixc_readback_pkg::*;
#(
    parameter int WIDTH = 21,
    parameter int BEAT  = 7
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] probe,
    input  logic             snap_req,
    output logic             snap_busy,
    output logic             snap_ovf,
    output logic             rd_valid,
    input  logic             rd_ready,
    output logic [BEAT-1:0]  rd_data,
    output logic [IDX_W-1:0] rd_idx,
    output logic             rd_last
`ifdef IXC_READBACK_PARITY_EN
    ,
    output logic             rd_par
`endif
);

    localparam int NB = num_beats(WIDTH, BEAT);

    state_e           state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             ovf_q, ovf_d;
    logic             load, adv, last;

    assign last = (state_q == SEND) && (idx_q == IDX_W'(NB - 1));

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        ovf_d   = ovf_q;
        load    = 1'b0;
        adv     = 1'b0;
        case (state_q)
            IDLE: begin
                if (snap_req) begin
                    load    = 1'b1;
                    state_d = SEND;
                    idx_d   = '0;
                    ovf_d   = 1'b0;
                end
            end
            SEND: begin
                // A request here, including on the final transfer edge,
                // is an overrun and never a capture.
                if (snap_req)
                    ovf_d = 1'b1;
                if (rd_ready) begin
                    adv = 1'b1;
                    if (last) begin
                        state_d = IDLE;
                        idx_d   = '0;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            ovf_q   <= ovf_d;
        end
    end

    ixc_readback_shreg #(
        .WIDTH (WIDTH),
        .BEAT  (BEAT)
    ) u_shreg (
        .clk    (clk),
        .rst    (rst),
        .load_i (load),
        .adv_i  (adv),
        .word_i (probe),
        .beat_o (rd_data)
    );

    assign rd_valid  = (state_q == SEND);
    assign snap_busy = (state_q == SEND);
    assign snap_ovf  = ovf_q;
    assign rd_idx    = idx_q;
    assign rd_last   = last;

`ifdef IXC_READBACK_PARITY_EN
    // Shadow is cleared in reset, so parity reads 0 there as well.
    assign rd_par = ^rd_data;
`endif

endmodule

// File: doc/ixc_readback_21.md
IXC_READBACK_21 -- requirements
Module: ixc_readback_21

Interface
REQ-001 Parameter: WIDTH, default 21, probe word width in bits.
REQ-002 Parameter: BEAT, default 7, readback beat width in bits.
REQ-003 Port: clk  input  1  sole clock; all state updates on rising edge.
REQ-004 Port: rst  input  1  reset, synchronous and active-high.
REQ-005 Port: probe  input  WIDTH  design word to be read back, the driven side of an assign path.
REQ-006 Port: snap_req  input  1  single-cycle request to capture probe.
REQ-007 Port: snap_busy  output  1  high from capture until the last beat is accepted.
REQ-008 Port: snap_ovf  output  1  sticky: snap_req arrived while busy.
REQ-009 Port: rd_valid  output  1  beat available.
REQ-010 Port: rd_ready  input  1  host accepts beat.
REQ-011 Port: rd_data  output  BEAT  current beat, LSB-first slice of the captured word.
REQ-012 Port: rd_idx  output  2  beat index, 0..NUM_BEATS-1.
REQ-013 Port: rd_last  output  1  current beat is the final one.

Function
REQ-014 NUM_BEATS SHALL be ceil(WIDTH/BEAT), 3 at defaults; bits of the last beat above WIDTH SHALL read 0.
REQ-015 FSM states SHALL be IDLE and SEND.
REQ-016 In IDLE with snap_req=1, probe SHALL be latched into the shadow register on that edge, and the state SHALL move to SEND with rd_idx=0.
REQ-017 rd_valid SHALL equal (state==SEND); it asserts the cycle after snap_req, giving one-cycle latency.
REQ-018 A beat transfers when rd_valid and rd_ready are both 1; on transfer rd_idx SHALL increment and rd_data SHALL present the next slice on the following cycle.
REQ-019 A transfer with rd_last=1 SHALL return to IDLE; rd_valid SHALL drop the next cycle.
REQ-020 While rd_valid=1 and rd_ready=0, rd_data, rd_idx and rd_last SHALL hold stable.
REQ-021 snap_busy SHALL equal (state==SEND).
REQ-022 snap_req in SEND SHALL be ignored for capture, SHALL set snap_ovf, and SHALL leave the shadow register unchanged.
REQ-023 snap_ovf SHALL clear on the next snap_req accepted in IDLE.
REQ-024 snap_req on the same edge as the final transfer SHALL count as overrun, not as a new capture.
REQ-025 Changes on probe after capture SHALL NOT affect beats in flight.

Reset
REQ-026 rst=1 SHALL force IDLE, rd_valid=0, snap_busy=0, snap_ovf=0, rd_idx=0, rd_last=0, rd_data=0, and shadow=0.
REQ-027 Reset mid-SEND SHALL abandon the transfer; no beat is valid on the cycle after rst deasserts.
REQ-028 snap_req coincident with rst SHALL be ignored.

Configuration
REQ-029 Macro IXC_READBACK_PARITY_EN defined: the block SHALL add output rd_par (1 bit, even parity over rd_data), held stable under the same rules as rd_data, and 0 in reset.
REQ-030 Macro undefined: rd_par SHALL be absent, and all other behaviour SHALL be unchanged.

Structure
REQ-031 Package ixc_readback_pkg SHALL hold the state enum (IDLE, SEND), the NUM_BEATS computation function and the index width constant.
REQ-032 Sub-module ixc_readback_shreg SHALL own the shadow register and beat slicing (load, advance, slice out); the FSM and handshake stay in the top module.

Verification
REQ-033 Scenario: probe=21'h1ABCDE, snap_req pulse, rd_ready=1 -> rd_data 7'h5E, 7'h79, 7'h6A on three consecutive cycles, rd_last on the third beat, snap_busy low the cycle after.
REQ-034 Scenario: rd_ready=0 for 4 cycles during beat 1 -> rd_data/rd_idx held at 7'h79/1, then complete normally.
REQ-035 Scenario: second snap_req during SEND with probe changed to 0 -> snap_ovf=1 and beats unchanged; next idle snap_req clears snap_ovf.
REQ-036 Scenario: rst asserted while rd_idx=1 -> all outputs 0 next cycle; a fresh snap_req then yields beat 0 of the new probe.
REQ-037 Scenario: snap_req on the same edge as the final transfer -> no new capture, snap_ovf=1, return to IDLE.
REQ-038 Scenario: with IXC_READBACK_PARITY_EN defined, probe=21'h000007 -> beat 0 rd_data=7'h07, rd_par=1; beats 1 and 2 have rd_par=0.
